// File: rtl/dshot_scheduler.sv
// Frame scheduler for four DShot transmitters: periodic packet compose,
// throttle clamping, round-robin telemetry and repeated special commands.
module dshot_scheduler #(
    parameter int FRAME_CLKS   = 400,
    parameter int CLKS_PER_BIT = 16,
    parameter int CMD_REPEAT   = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arm,
    input  logic [43:0] throttle,
    input  logic        tlm_en,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_motor,
    input  logic [5:0]  cmd_value,
    output logic        cmd_ready,
    output logic        cmd_active,
    output logic [63:0] packets,
    output logic [3:0]  load
);

    localparam int TW = $clog2(FRAME_CLKS);
    localparam int CW = $clog2(CMD_REPEAT + 1);
    localparam logic [TW-1:0] RELOAD = TW'(FRAME_CLKS - 1);

    if (FRAME_CLKS < 16 * CLKS_PER_BIT + 2) begin : g_bad_frame
        $error("FRAME_CLKS too short for one DShot frame");
    end

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    motor_q, motor_d;
    logic [5:0]    code_q, code_d;
    logic [63:0]   packets_q, packets_d;
    logic [3:0]    load_q, load_d;
    logic          compose;

    function automatic logic [15:0] encode(logic [10:0] value, logic tlm);
        logic [11:0] data;
        data = {value, tlm};
        return {data, data[11:8] ^ data[7:4] ^ data[3:0]};
    endfunction

    always_comb begin
        logic [10:0] thr;
        logic [10:0] val;
        logic        tlm;
        thr       = '0;
        val       = '0;
        tlm       = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        motor_d   = motor_q;
        code_d    = code_q;
        packets_d = packets_q;
        load_d    = '0;
        compose   = (timer_q == '0);
        timer_d   = compose ? RELOAD : timer_q - 1'b1;
        cmd_ready = (state_q == IDLE) && !arm;

        if (cmd_valid && cmd_ready) begin
            state_d = ACTIVE;
            motor_d = cmd_motor;
            code_d  = cmd_value;
            cnt_d   = CW'(CMD_REPEAT);
        end

        if (compose) begin
            load_d = '1;
            for (int i = 0; i < 4; i++) begin
                thr = throttle[11*i +: 11];
                if (!arm)
                    val = '0;
                else if (thr != '0 && thr < 11'd48)
                    val = 11'd48;
                else
                    val = thr;
                tlm = tlm_en && (ptr_q == 2'(i));
                // An arming event wins over a pending command on that frame
                if (state_q == ACTIVE && !arm && motor_q == 2'(i)) begin
                    val = {5'b0, code_q};
                    tlm = 1'b1;
                end
                packets_d[16*i +: 16] = encode(val, tlm);
            end
            if (tlm_en)
                ptr_d = ptr_q + 2'd1;
            if (state_q == ACTIVE) begin
                if (arm) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1))
                        state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= RELOAD;
            cnt_q     <= '0;
            ptr_q     <= '0;
            motor_q   <= '0;
            code_q    <= '0;
            packets_q <= '0;
            load_q    <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            motor_q   <= motor_d;
            code_q    <= code_d;
            packets_q <= packets_d;
            load_q    <= load_d;
        end
    end

    assign cmd_active = (state_q == ACTIVE);
    assign packets    = packets_q;
    assign load       = load_q;

endmodule

// File: tb/tb_dshot_scheduler.sv
// Directed bench for dshot_scheduler: frame timing, encoding, telemetry,
// command repeat/abort and mid-command reset.
module tb_dshot_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        arm;
    logic [43:0] throttle;
    logic        tlm_en;
    logic        cmd_valid;
    logic [1:0]  cmd_motor;
    logic [5:0]  cmd_value;
    logic        cmd_ready;
    logic        cmd_active;
    logic [63:0] packets;
    logic [3:0]  load;

    int checks = 0;
    int errors = 0;

    dshot_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .arm        (arm),
        .throttle   (throttle),
        .tlm_en     (tlm_en),
        .cmd_valid  (cmd_valid),
        .cmd_motor  (cmd_motor),
        .cmd_value  (cmd_value),
        .cmd_ready  (cmd_ready),
        .cmd_active (cmd_active),
        .packets    (packets),
        .load       (load)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Steps edges until a load strobe is seen; bounded so a dead DUT still ends.
    task automatic wait_load(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (load == 4'h0 && n < 1000);
    endtask

    initial begin
        int n;
        logic [63:0] exp;

        reset     = 1'b1;
        arm       = 1'b0;
        throttle  = '0;
        tlm_en    = 1'b0;
        cmd_valid = 1'b0;
        cmd_motor = '0;
        cmd_value = '0;
        repeat (3) tick();
        chk("rst_packets", packets, 64'h0);
        chk("rst_load", 64'(load), 64'h0);
        chk("rst_ready_disarmed", 64'(cmd_ready), 64'h1);
        chk("rst_active", 64'(cmd_active), 64'h0);
        arm = 1'b1;
        #1;
        chk("rst_ready_armed", 64'(cmd_ready), 64'h0);
        arm = 1'b0;

        reset = 1'b0;
        wait_load(n);
        chk("first_load_edge", 64'(n), 64'd400);
        chk("first_load_val", 64'(load), 64'hF);
        chk("first_packets", packets, 64'h0);
        tick();
        chk("load_one_cycle", 64'(load), 64'h0);
        wait_load(n);
        chk("second_load_gap", 64'(n), 64'd399);

        arm = 1'b1;
        throttle = {11'd0, 11'd0, 11'd0, 11'd1046};
        wait_load(n);
        chk("armed_gap", 64'(n), 64'd400);
        chk("thr_1046", packets, 64'h0000_0000_0000_82C6);
        throttle = {11'd47, 11'd0, 11'd2047, 11'd20};
        wait_load(n);
        chk("thr_clamp_max", packets, 64'h0606_0000_FFEE_0606);

        throttle = {4{11'd48}};
        tlm_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_load(n);
            exp = {4{16'h0606}};
            exp[16*(k%4) +: 16] = 16'h0617;
            chk($sformatf("tlm_rr_%0d", k), packets, exp);
        end
        tlm_en = 1'b0;
        wait_load(n);
        chk("tlm_off_a", packets, {4{16'h0606}});
        wait_load(n);
        chk("tlm_off_b", packets, {4{16'h0606}});
        tlm_en = 1'b1;
        wait_load(n);
        chk("tlm_ptr_frozen", packets, 64'h0606_0606_0617_0606);
        tlm_en = 1'b0;

        arm = 1'b0;
        throttle = '0;
        wait_load(n);
        chk("disarmed_zero", packets, 64'h0);
        chk("ready_idle", 64'(cmd_ready), 64'h1);
        cmd_valid = 1'b1;
        cmd_motor = 2'd2;
        cmd_value = 6'd1;
        tick();
        cmd_valid = 1'b0;
        chk("cmd_accept", 64'(cmd_active), 64'h1);
        chk("ready_busy", 64'(cmd_ready), 64'h0);
        for (int f = 1; f <= 10; f++) begin
            wait_load(n);
            chk($sformatf("cmd_frame_%0d", f), packets, 64'h0000_0033_0000_0000);
            if (f < 10) begin
                chk($sformatf("cmd_active_%0d", f), 64'(cmd_active), 64'h1);
            end else begin
                chk("cmd_done_active", 64'(cmd_active), 64'h0);
                chk("cmd_done_ready", 64'(cmd_ready), 64'h1);
            end
            if (f == 3) begin
                cmd_valid = 1'b1;
                cmd_motor = 2'd1;
                cmd_value = 6'd5;
                tick();
                cmd_valid = 1'b0;
            end
        end
        wait_load(n);
        chk("cmd_frame_11", packets, 64'h0);
        chk("ignored_cmd", 64'(cmd_active), 64'h0);

        repeat (399) tick();
        cmd_valid = 1'b1;
        cmd_motor = 2'd2;
        cmd_value = 6'd1;
        tick();
        cmd_valid = 1'b0;
        chk("compose_acc_load", 64'(load), 64'hF);
        chk("compose_acc_frame", packets, 64'h0);
        chk("compose_acc_active", 64'(cmd_active), 64'h1);
        for (int f = 1; f <= 3; f++) begin
            wait_load(n);
            chk($sformatf("abort_pre_%0d", f), packets, 64'h0000_0033_0000_0000);
        end
        arm = 1'b1;
        throttle = {11'd0, 11'd1046, 11'd0, 11'd0};
        wait_load(n);
        chk("abort_frame", packets, 64'h0000_82C6_0000_0000);
        chk("abort_active", 64'(cmd_active), 64'h0);
        chk("armed_ready", 64'(cmd_ready), 64'h0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("armed_cmd_ignored", 64'(cmd_active), 64'h0);

        arm = 1'b0;
        throttle = '0;
        wait_load(n);
        cmd_valid = 1'b1;
        cmd_motor = 2'd2;
        cmd_value = 6'd1;
        tick();
        cmd_valid = 1'b0;
        wait_load(n);
        chk("pre_reset_cmd", packets, 64'h0000_0033_0000_0000);
        repeat (100) tick();
        reset = 1'b1;
        #1;
        chk("midrst_load", 64'(load), 64'h0);
        chk("midrst_packets", packets, 64'h0);
        chk("midrst_active", 64'(cmd_active), 64'h0);
        repeat (2) tick();
        reset = 1'b0;
        wait_load(n);
        chk("post_rst_gap", 64'(n), 64'd400);
        chk("post_rst_packets", packets, 64'h0);
        chk("post_rst_active", 64'(cmd_active), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
